// File: rtl/ibex_core_sleep_ctrl.sv
// rtl/ibex_core_sleep_ctrl.sv - idle-hold sleep controller gating the core clock
module ibex_core_sleep_ctrl #(
    parameter bit          SecureIbex     = 1'b0,
    parameter int unsigned IdleHoldCycles = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [3:0] core_busy_i,
    input  logic       sleep_allow_i,
    input  logic       wake_req_i,
    output logic       clock_en_o,
    output logic       core_sleep_o,
    output logic       busy_err_o
);

    localparam logic [3:0] IbexMuBiOn  = 4'b0101;
    localparam logic [3:0] IbexMuBiOff = 4'b1010;

    localparam int unsigned CntW = (IdleHoldCycles == 0) ? 1 : $clog2(IdleHoldCycles + 1);
    localparam logic [CntW-1:0] CntLoad =
        (IdleHoldCycles == 0) ? '0 : CntW'(IdleHoldCycles - 1);

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SLEEP  = 2'd2,
        WAKE   = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_err_q, busy_err_d;

    logic busy_on;
    logic busy_off;
    logic busy_invalid;
    logic sleep_cond;

    // Only the exact Off encoding counts as idle; anything else keeps the core awake.
    assign busy_on      = (core_busy_i == IbexMuBiOn);
    assign busy_off     = (core_busy_i == IbexMuBiOff);
    assign busy_invalid = ~busy_on & ~busy_off;
    assign sleep_cond   = busy_off & sleep_allow_i & ~wake_req_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ACTIVE: begin
                if (sleep_cond) begin
                    if (IdleHoldCycles == 0) begin
                        state_d = SLEEP;
                    end else begin
                        state_d = DRAIN;
                        cnt_d   = CntLoad;
                    end
                end
            end
            DRAIN: begin
                // Abort is checked before expiry so a late wake never lands in SLEEP.
                if (!sleep_cond) begin
                    state_d = ACTIVE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = SLEEP;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            SLEEP: begin
                if (wake_req_i || !busy_off) begin
                    state_d = WAKE;
                end
            end
            WAKE: begin
                state_d = ACTIVE;
            end
            default: begin
                state_d = ACTIVE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        busy_err_d = busy_invalid;
        if (SecureIbex) begin
            busy_err_d = busy_err_q | busy_invalid;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ACTIVE;
            cnt_q      <= '0;
            busy_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            busy_err_q <= busy_err_d;
        end
    end

    assign clock_en_o   = (state_q != SLEEP);
    assign core_sleep_o = (state_q == SLEEP);
    assign busy_err_o   = busy_err_q;

endmodule
